// File: rtl/zipo_mem_arbiter.sv
// zipo_mem_arbiter
//
// Shares the core's single memory port between the instruction-fetch
// requester (IF, reads only) and the load/store requester (LS, reads and
// writes). Each access is sequenced by a two-state FSM. After the grant the
// FSM waits a fixed MEM_LATENCY cycles, then captures the memory read bus.
// When both requesters ask at once, the one that was not granted last wins.
//
// Parameters
//   ADDR_W       address width
//   DATA_W       data width
//   MEM_LATENCY  cycles from mem_addr registered to mem_read valid (1..15)
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   if_req/if_addr            fetch request; held until if_gnt
//   if_gnt                    one-cycle pulse: fetch accepted
//   if_rvalid/if_rdata        one-cycle pulse with the fetched word
//   ls_req/ls_we/ls_addr/
//   ls_wdata                  load/store request; held until ls_gnt
//   ls_gnt                    one-cycle pulse: load/store accepted
//   ls_done/ls_rdata          one-cycle completion pulse; load data on reads
//   mem_rw/mem_addr/mem_write memory write enable, address, write data
//   mem_read                  memory read data
module zipo_mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write,
    input  logic [DATA_W-1:0] mem_read
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    owner_t           last_grant;   // also the owner of the access in flight
    logic [CNT_W-1:0] cnt;
    logic             pick_ls;

    // LS wins when it is the only requester, or on a tie when IF was
    // granted last. Resetting last_grant to LS hands the first tie to IF.
    always_comb begin
        pick_ls = ls_req && (!if_req || (last_grant == OWN_IF));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= OWN_LS;
            cnt        <= '0;
            if_gnt     <= 1'b0;
            ls_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            ls_done    <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_write  <= '0;
        end else begin
            // Handshake outputs are single-cycle pulses.
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_done   <= 1'b0;

            case (state)
                IDLE: begin
                    mem_rw <= 1'b0;
                    if (if_req || ls_req) begin
                        if (pick_ls) begin
                            mem_addr   <= ls_addr;
                            mem_rw     <= ls_we;
                            mem_write  <= ls_wdata;
                            ls_gnt     <= 1'b1;
                            last_grant <= OWN_LS;
                        end else begin
                            mem_addr   <= if_addr;
                            if_gnt     <= 1'b1;
                            last_grant <= OWN_IF;
                        end
                        cnt   <= CNT_INIT;
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (last_grant == OWN_IF) begin
                            if_rdata  <= mem_read;
                            if_rvalid <= 1'b1;
                        end else begin
                            // mem_rw still reflects ls_we of the access in
                            // flight, so a store leaves ls_rdata untouched.
                            if (!mem_rw) begin
                                ls_rdata <= mem_read;
                            end
                            ls_done <= 1'b1;
                        end
                        mem_rw <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/zipo_mem_arbiter.md
Name: zipo_mem_arbiter

Overview:
Shares the CPU's single 64-bit memory port between two requesters. The instruction-fetch requester (IF) issues reads. The load/store requester (LS) issues reads or writes. The block sits between the core and the memory, and drives the memory's rw/addr/write signals while capturing its read bus. A small FSM sequences each access over a fixed memory read latency and arbitrates between requesters round-robin.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MEM_LATENCY, 1, cycles from mem_addr registered to mem_read valid (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched 64-bit word (core selects 32-bit half)
ls_req  in  1  load/store request; held with ls_we/ls_addr/ls_wdata stable until ls_gnt
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_gnt  out  1  one-cycle pulse: LS accepted
ls_done  out  1  one-cycle pulse: LS access complete (read or write)
ls_rdata  out  DATA_W  load data, valid with ls_done when ls_we was 0
mem_rw  out  1  memory write enable (1 = write)
mem_addr  out  ADDR_W  memory address
mem_write  out  DATA_W  memory write data
mem_read  in  DATA_W  memory read data

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, last_grant=LS. All outputs are 0, including mem_rw, mem_addr, mem_write, both rdata, and all pulses.
- FSM states: IDLE and BUSY. There is no other state.
- IDLE, no request: remain in IDLE; mem_rw=0; mem_addr and mem_write hold their values.
- IDLE, at least one request, at the clock edge:
  - Select the winner.
  - Register mem_addr from the winner's address.
  - Set mem_rw = winner is LS and ls_we is 1.
  - Set mem_write = ls_wdata for an LS winner; hold it for an IF winner.
  - Set the winner's gnt=1 for exactly the next cycle.
  - Set cnt=MEM_LATENCY-1, last_grant=winner, state=BUSY.
- Arbitration:
  - Only one request: that requester wins.
  - Both requesting: the requester that is not last_grant wins.
  - The first tie after reset goes to IF.
- BUSY: if cnt!=0, decrement cnt. If cnt==0, at the edge:
  - Capture mem_read into the owner's rdata; reads only. On a write, ls_rdata holds its value.
  - Pulse if_rvalid (IF read) or ls_done (LS read or write) for the next cycle.
  - Force mem_rw=0 and set state=IDLE.
- mem_rw is high for exactly MEM_LATENCY cycles per write.
- Latency and throughput:
  - Request sampled in IDLE at edge E.
  - gnt is high in cycle E+1.
  - The done/rvalid pulse is high in the cycle after edge E+MEM_LATENCY.
  - A new request may be accepted in the same IDLE cycle that carries a done/rvalid pulse.
  - Back-to-back throughput is one access per MEM_LATENCY+1 cycles.
- Requests asserted during BUSY wait; they are not dropped. A requester deasserting req before gnt withdraws with no effect.
- gnt and done/rvalid for the same requester never coincide. if_gnt and ls_gnt never coincide.
- Reset mid-BUSY: the transaction is abandoned. No done/rvalid pulse is produced, and mem_rw drops to 0 immediately.
- rdata outputs hold their last captured value until the next read completes for that requester.

Test Plan:
1. Reset, then if_req=1 with if_addr=0x1000, MEM_LATENCY=1, mem_read=0xDEADBEEF_00000013 -> if_gnt high in cycle 1 with mem_addr=0x1000, mem_rw=0; if_rvalid high in cycle 2 with if_rdata=0xDEADBEEF_00000013.
2. LS write with ls_addr=0x2000, ls_wdata=0x55 -> ls_gnt; mem_rw=1, mem_addr=0x2000, mem_write=0x55 for 1 cycle; ls_done next cycle; ls_rdata unchanged; mem_rw returns to 0.
3. Both requesters hold req continuously after reset -> grant order IF, LS, IF, LS; one access every 2 cycles at MEM_LATENCY=1 (every 4 at MEM_LATENCY=3).
4. MEM_LATENCY=3, LS read at 0x3000 -> ls_done exactly 3 cycles after ls_gnt; a request asserted by IF during BUSY is granted in the cycle after ls_done.
5. Assert rst during BUSY of an LS write -> mem_rw=0 in the same cycle; no ls_done; next tie after release is granted to IF.
6. if_req pulsed for 1 cycle while BUSY, then dropped -> no if_gnt, no memory access to if_addr.
